// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-read-port register file.
// Optional feature macro: REGFILE_MP_BYPASS_EN (write-to-read forwarding).
package regfile_mp_pkg;

    localparam int unsigned DEF_DW = 32;
    localparam int unsigned DEF_AW = 5;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_RUN
    } state_e;

    // Number of registers addressed by an aw-bit address.
    function automatic int unsigned calc_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the register file: read ports, write port, reserve port.
interface regfile_mp_if #(
    parameter int unsigned DW  = regfile_mp_pkg::DEF_DW,
    parameter int unsigned AW  = regfile_mp_pkg::DEF_AW,
    parameter int unsigned NRD = 2
);

    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_ready;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic              init_done;

    // Pipeline side (decode + writeback).
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, wr_ready, init_done
    );

    // Register file side.
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, wr_ready, init_done
    );

endinterface

// File: rtl/regfile_mp_init_seq.sv
// Post-reset initialisation sequencer: writes gpr[i] = i for every entry, then
// moves to RUN. init_done comes straight from the state register.
module regfile_mp_init_seq #(
    parameter int unsigned DW = regfile_mp_pkg::DEF_DW,
    parameter int unsigned AW = regfile_mp_pkg::DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic [DW-1:0] init_data,
    output logic          init_done
);
    import regfile_mp_pkg::*;

    localparam int unsigned DEPTH = calc_depth(AW);

    state_e        state_q, state_d;
    // One bit wider than the address so the last increment does not wrap.
    logic [AW:0]   cnt_q, cnt_d;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: one entry per cycle in INIT, leave after entry DEPTH-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == (AW+1)'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign init_addr = cnt_q[AW-1:0];
    assign init_data = DW'(cnt_q[AW-1:0]);
    assign init_done = (state_q == ST_RUN);

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with post-reset init sequencer and
// per-register pending bits. Optional macro: REGFILE_MP_BYPASS_EN forwards an
// accepted write to matching read ports in the same cycle.
module regfile_mp #(
    parameter int unsigned DW      = regfile_mp_pkg::DEF_DW,
    parameter int unsigned AW      = regfile_mp_pkg::DEF_AW,
    parameter int unsigned NRD     = 2,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mp_if.slave   bus
);
    import regfile_mp_pkg::*;

    localparam int unsigned DEPTH = calc_depth(AW);
    localparam bit          ZR0   = (ZERO_R0 != 0);

    logic             init_we;
    logic [AW-1:0]    init_addr;
    logic [DW-1:0]    init_data;
    logic             run;

    logic [DW-1:0]    gpr [DEPTH];
    logic [DEPTH-1:0] pending_q, pending_d;

    logic             wr_fire, rsv_fire;
    logic             wr_keep, rsv_keep;
    logic [AW-1:0]    ra;

    regfile_mp_init_seq #(
        .DW (DW),
        .AW (AW)
    ) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .init_done (run)
    );

    assign bus.wr_ready  = run;
    assign bus.init_done = run;

    assign wr_fire  = bus.wr_en & run;
    assign rsv_fire = bus.rsv_en & run;
    // Register 0 is hardwired when ZR0 is set: drop writes and reserves to it.
    assign wr_keep  = wr_fire & ~(ZR0 & (bus.wr_addr == '0));
    assign rsv_keep = rsv_fire & ~(ZR0 & (bus.rsv_addr == '0));

    // Storage: init writes own the array until RUN; no reset on the data.
    always_ff @(posedge clk) begin
        if (init_we) begin
            gpr[init_addr] <= init_data;
        end else if (wr_keep) begin
            gpr[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Pending next-state: write clears, reserve sets; reserve applied last so it wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_keep) begin
            pending_d[bus.wr_addr] = 1'b0;
        end
        if (rsv_keep) begin
            pending_d[bus.rsv_addr] = 1'b1;
        end
    end

    // Pending bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Combinational read ports, all zero until RUN.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        ra          = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = bus.rd_addr[k*AW +: AW];
            if (run && !(ZR0 && (ra == '0))) begin
                bus.rd_data[k*DW +: DW] = gpr[ra];
                bus.rd_busy[k]          = pending_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
                if (wr_fire && (bus.wr_addr == ra)) begin
                    bus.rd_data[k*DW +: DW] = bus.wr_data;
                    bus.rd_busy[k]          = rsv_fire && (bus.rsv_addr == ra);
                end
`endif
            end
        end
    end

endmodule
